// File: rtl/led_pkg.sv
// Shared definitions for the debug-LED blink arbiter: FSM encoding, code width
// and the default timing of one blink sequence.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } led_state_e;

  localparam int CODE_W = 3;
  localparam int UNIT_W = 8;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_T_UNIT    = 2500000;
  localparam int DEF_ON_UNITS  = 2;
  localparam int DEF_OFF_UNITS = 2;
  localparam int DEF_GAP_UNITS = 10;
  localparam int DEF_HB_UNITS  = 6;
  localparam int DEF_CNT_W     = 26;

endpackage

// File: rtl/led_tick_gen.sv
// Time-unit prescaler: counts 0..T_UNIT-1 and flags the last count of each unit.
// A synchronous clear restarts the unit so every phase starts on a unit boundary.
module led_tick_gen #(
  parameter int T_UNIT = 2500000,
  parameter int CNT_W  = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(T_UNIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/led_blink_arbiter.sv
// Shares one debug LED between N_REQ requesters: fixed-priority grant, then the
// granted blink code plays as ON/OFF pulses plus a gap; heartbeat when idle.
module led_blink_arbiter
  import led_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int T_UNIT    = DEF_T_UNIT,
  parameter int ON_UNITS  = DEF_ON_UNITS,
  parameter int OFF_UNITS = DEF_OFF_UNITS,
  parameter int GAP_UNITS = DEF_GAP_UNITS,
  parameter int HB_UNITS  = DEF_HB_UNITS,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                    I_clk,
  input  logic                    I_reset,
  input  logic                    I_enable,
  input  logic [N_REQ-1:0]        I_req,
  input  logic [CODE_W*N_REQ-1:0] I_code,
  output logic                    O_led,
  output logic [N_REQ-1:0]        O_grant,
  output logic                    O_busy,
  output logic                    O_done
);

  localparam logic [UNIT_W-1:0] ON_LAST  = UNIT_W'(ON_UNITS - 1);
  localparam logic [UNIT_W-1:0] OFF_LAST = UNIT_W'(OFF_UNITS - 1);
  localparam logic [UNIT_W-1:0] GAP_LAST = UNIT_W'(GAP_UNITS - 1);
  localparam logic [UNIT_W-1:0] HB_LAST  = UNIT_W'(HB_UNITS - 1);

  led_state_e        state, state_next;
  logic [UNIT_W-1:0] unit_cnt, unit_next, unit_last;
  logic [CODE_W-1:0] rem, rem_next;
  logic [N_REQ-1:0]  sel_onehot, grant_next;
  logic [CODE_W-1:0] sel_code;
  logic              tick, phase_end, hb_wrap;
  logic              led_next, busy_next, done_next;

  led_tick_gen #(
    .T_UNIT (T_UNIT),
    .CNT_W  (CNT_W)
  ) u_tick (
    .clk  (I_clk),
    .rst  (I_reset),
    .clr  (state_next != state),
    .tick (tick)
  );

  // Lowest eligible index wins; a zero code never counts as a request.
  always_comb begin
    sel_onehot = '0;
    sel_code   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (I_req[k] && (I_code[k*CODE_W +: CODE_W] != '0)) begin
        sel_onehot    = '0;
        sel_onehot[k] = 1'b1;
        sel_code      = I_code[k*CODE_W +: CODE_W];
      end
    end
  end

  always_comb begin
    state_next = state;
    rem_next   = rem;
    grant_next = O_grant;
    done_next  = 1'b0;
    unit_last  = HB_LAST;
    case (state)
      ST_ON:   unit_last = ON_LAST;
      ST_OFF:  unit_last = OFF_LAST;
      ST_GAP:  unit_last = GAP_LAST;
      default: unit_last = HB_LAST;
    endcase
    phase_end = tick && (unit_cnt == unit_last);
    hb_wrap   = (state == ST_IDLE) && phase_end;

    case (state)
      ST_IDLE: begin
        if (I_enable && (sel_onehot != '0)) begin
          state_next = ST_ON;
          rem_next   = sel_code;
          grant_next = sel_onehot;
        end
      end
      ST_ON: begin
        if (!I_enable) begin
          state_next = ST_IDLE;
        end else if (phase_end) begin
          state_next = ST_OFF;
          rem_next   = rem - 1'b1;
        end
      end
      ST_OFF: begin
        if (!I_enable) begin
          state_next = ST_IDLE;
        end else if (phase_end) begin
          state_next = (rem != '0) ? ST_ON : ST_GAP;
        end
      end
      ST_GAP: begin
        if (!I_enable) begin
          state_next = ST_IDLE;
        end else if (phase_end) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (state_next == ST_IDLE) begin
      grant_next = '0;
    end
    busy_next = (state_next != ST_IDLE);

    // Unit counter doubles as the heartbeat counter while idle.
    if (state_next != state) begin
      unit_next = '0;
    end else if (tick) begin
      unit_next = hb_wrap ? '0 : unit_cnt + 1'b1;
    end else begin
      unit_next = unit_cnt;
    end

    case (state_next)
      ST_ON:   led_next = 1'b1;
      ST_IDLE: led_next = (state != ST_IDLE) ? 1'b0 : (hb_wrap ? ~O_led : O_led);
      default: led_next = 1'b0;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state    <= ST_IDLE;
      unit_cnt <= '0;
      rem      <= '0;
      O_led    <= 1'b0;
      O_grant  <= '0;
      O_busy   <= 1'b0;
      O_done   <= 1'b0;
    end else begin
      state    <= state_next;
      unit_cnt <= unit_next;
      rem      <= rem_next;
      O_led    <= led_next;
      O_grant  <= grant_next;
      O_busy   <= busy_next;
      O_done   <= done_next;
    end
  end

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Directed bench for led_blink_arbiter with short timing (1 unit = 4 cycles).
// Expected output-change events (cycles since previous change + outputs) are queued.
module tb_led_blink_arbiter;

  localparam int ON_C  = 8;
  localparam int OFF_C = 8;
  localparam int GAP_C = 12;
  localparam int W     = 23;

  logic        I_clk;
  logic        I_reset;
  logic        I_enable;
  logic [3:0]  I_req;
  logic [11:0] I_code;
  logic        O_led;
  logic [3:0]  O_grant;
  logic        O_busy;
  logic        O_done;

  logic [W-1:0] exp_q[$];
  int checks;
  int errors;
  int cyc;
  int edge_n;
  bit stim_done;

  led_blink_arbiter #(
    .N_REQ     (4),
    .T_UNIT    (4),
    .ON_UNITS  (2),
    .OFF_UNITS (2),
    .GAP_UNITS (3),
    .HB_UNITS  (5),
    .CNT_W     (26)
  ) dut (
    .I_clk    (I_clk),
    .I_reset  (I_reset),
    .I_enable (I_enable),
    .I_req    (I_req),
    .I_code   (I_code),
    .O_led    (O_led),
    .O_grant  (O_grant),
    .O_busy   (O_busy),
    .O_done   (O_done)
  );

  // Clock and cycle counter
  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  initial cyc = 0;
  always @(posedge I_clk) cyc <= cyc + 1;

  // Driver helpers
  task automatic goto_edge(input int e);
    repeat (e - edge_n) @(negedge I_clk);
    edge_n = e;
  endtask

  task automatic set_code(input int k, input logic [2:0] v);
    I_code[k*3 +: 3] = v;
  endtask

  task automatic exp_evt(input int dly, input logic led, input logic [3:0] g,
                         input logic busy, input logic done);
    exp_q.push_back({16'(dly), led, g, busy, done});
  endtask

  // One complete natural play: first ON after first_dly, ends with the done pulse.
  task automatic exp_play(input int first_dly, input logic [3:0] g, input int code);
    exp_evt(first_dly, 1'b1, g, 1'b1, 1'b0);
    for (int i = 0; i < code; i++) begin
      exp_evt(ON_C, 1'b0, g, 1'b1, 1'b0);
      if (i < code - 1) exp_evt(OFF_C, 1'b1, g, 1'b1, 1'b0);
    end
    exp_evt(OFF_C + GAP_C, 1'b0, 4'b0000, 1'b0, 1'b1);
  endtask

  // Stimulus
  initial begin : stimulus
    I_reset = 1'b1;
    I_enable = 1'b1;
    I_req = '0;
    I_code = '0;
    stim_done = 1'b0;
    edge_n = 0;
    repeat (3) @(negedge I_clk);
    #1 I_reset = 1'b0;
    edge_n = 0;

    // Heartbeat with nothing requested
    exp_evt(20, 1'b1, 4'b0000, 1'b0, 1'b0);
    exp_evt(20, 1'b0, 4'b0000, 1'b0, 1'b0);
    exp_evt(20, 1'b1, 4'b0000, 1'b0, 1'b0);

    // Code 3 on requester 2, request dropped after grant
    goto_edge(69);
    I_req = 4'b0100;
    set_code(2, 3'd3);
    exp_play(10, 4'b0100, 3);
    exp_evt(1, 1'b0, 4'b0000, 1'b0, 1'b0);
    goto_edge(70);
    I_req = 4'b0000;

    // Simultaneous requests 1 and 3; held request 1 repeats, then 3 plays
    goto_edge(131);
    I_req = 4'b1010;
    set_code(1, 3'd2);
    set_code(3, 3'd5);
    exp_play(1, 4'b0010, 2);
    exp_play(1, 4'b0010, 2);
    exp_play(1, 4'b1000, 5);
    exp_evt(1, 1'b0, 4'b0000, 1'b0, 1'b0);
    goto_edge(180);
    I_req = 4'b1000;
    goto_edge(230);
    I_req = 4'b0000;
    set_code(3, 3'd1);

    // Zero code is ignored; higher priority arrival waits for the current play
    goto_edge(316);
    I_req = 4'b0101;
    set_code(0, 3'd0);
    set_code(2, 3'd1);
    exp_play(2, 4'b0100, 1);
    exp_play(1, 4'b0010, 1);
    exp_evt(1, 1'b0, 4'b0000, 1'b0, 1'b0);
    exp_evt(19, 1'b1, 4'b0000, 1'b0, 1'b0);
    exp_evt(20, 1'b0, 4'b0000, 1'b0, 1'b0);
    goto_edge(318);
    I_req = 4'b0001;
    goto_edge(320);
    I_req = 4'b0011;
    set_code(1, 3'd1);
    goto_edge(347);
    I_req = 4'b0001;

    // Enable drops during the second ON of a code-3 play
    goto_edge(419);
    I_req = 4'b0100;
    set_code(2, 3'd3);
    exp_evt(6, 1'b1, 4'b0100, 1'b1, 1'b0);
    exp_evt(ON_C, 1'b0, 4'b0100, 1'b1, 1'b0);
    exp_evt(OFF_C, 1'b1, 4'b0100, 1'b1, 1'b0);
    exp_evt(4, 1'b0, 4'b0000, 1'b0, 1'b0);
    exp_evt(20, 1'b1, 4'b0000, 1'b0, 1'b0);
    exp_evt(20, 1'b0, 4'b0000, 1'b0, 1'b0);
    exp_evt(20, 1'b1, 4'b0000, 1'b0, 1'b0);
    goto_edge(439);
    I_enable = 1'b0;
    I_req = 4'b0000;
    goto_edge(485);
    I_enable = 1'b1;

    // Asynchronous reset in the middle of an OFF phase, request kept pending
    goto_edge(504);
    I_req = 4'b0010;
    set_code(1, 3'd2);
    exp_evt(5, 1'b1, 4'b0010, 1'b1, 1'b0);
    exp_evt(ON_C, 1'b0, 4'b0010, 1'b1, 1'b0);
    goto_edge(516);
    #2 I_reset = 1'b1;
    exp_play(1, 4'b0010, 2);
    exp_evt(1, 1'b0, 4'b0000, 1'b0, 1'b0);
    repeat (3) @(negedge I_clk);
    #1 I_reset = 1'b0;
    edge_n = 0;
    goto_edge(2);
    I_req = 4'b0000;
    goto_edge(55);
    stim_done = 1'b1;
  end

  // Monitor and scoreboard
  initial begin : monitor
    logic [6:0]   prev;
    logic [6:0]   cur;
    logic [W-1:0] act;
    logic [W-1:0] exp;
    int           last_cyc;
    int           n_evt;
    bit           rst_seen;
    checks = 0;
    errors = 0;
    prev = '0;
    last_cyc = 0;
    n_evt = 0;
    rst_seen = 1'b0;
    while (!stim_done) begin
      @(negedge I_clk or posedge I_reset);
      if (I_reset && !rst_seen) begin
        #1;
        cur = {O_led, O_grant, O_busy, O_done};
        checks++;
        if (cur !== 7'b0) begin
          errors++;
          $display("FAIL reset_outputs: got led,grant,busy,done=%b required 0000000", cur);
        end
        rst_seen = 1'b1;
      end else if (I_reset) begin
        prev = '0;
        last_cyc = cyc;
      end else begin
        rst_seen = 1'b0;
        cur = {O_led, O_grant, O_busy, O_done};
        if (cur !== prev) begin
          act = {16'(cyc - last_cyc), cur};
          n_evt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event_%0d: unexpected change after %0d cycles to led=%b grant=%b busy=%b done=%b",
                     n_evt, act[22:7], act[6], act[5:2], act[1], act[0]);
          end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
              errors++;
              $display("FAIL event_%0d: got dly=%0d led=%b grant=%b busy=%b done=%b required dly=%0d led=%b grant=%b busy=%b done=%b",
                       n_evt, act[22:7], act[6], act[5:2], act[1], act[0],
                       exp[22:7], exp[6], exp[5:2], exp[1], exp[0]);
            end
          end
          prev = cur;
          last_cyc = cyc;
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d unconsumed expected events required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
